// File: rtl/ex_mem_skid_stage.sv
// Execute-to-memory stage: 2-entry skid buffer with EX->EX forwarding and load-use detection.
// Optional stall-cycle counter is enabled by defining EX_MEM_PERF_CNT_EN.
module ex_mem_skid_stage #(
  parameter int DATA_WIDTH    = 32,
  parameter int REG_IDX_WIDTH = 4
) (
  input  logic                     clk_i,
  input  logic                     reset_n_i,
  input  logic                     flush_i,
  input  logic                     valid_i,
  output logic                     ready_o,
  input  logic [DATA_WIDTH-1:0]    alu_result_i,
  input  logic [DATA_WIDTH-1:0]    store_data_i,
  input  logic [REG_IDX_WIDTH-1:0] dest_reg_i,
  input  logic                     reg_write_en_i,
  input  logic                     mem_read_i,
  input  logic                     mem_write_i,
  input  logic [1:0]               mem_size_i,
  output logic                     valid_o,
  input  logic                     ready_i,
  output logic [DATA_WIDTH-1:0]    alu_result_o,
  output logic [DATA_WIDTH-1:0]    store_data_o,
  output logic [REG_IDX_WIDTH-1:0] dest_reg_o,
  output logic                     reg_write_en_o,
  output logic                     mem_read_o,
  output logic                     mem_write_o,
  output logic [1:0]               mem_size_o,
  input  logic [REG_IDX_WIDTH-1:0] fwd_query_1_i,
  input  logic [REG_IDX_WIDTH-1:0] fwd_query_2_i,
  output logic                     fwd_hit_1_o,
  output logic                     fwd_hit_2_o,
  output logic [DATA_WIDTH-1:0]    fwd_data_1_o,
  output logic [DATA_WIDTH-1:0]    fwd_data_2_o,
  output logic                     load_use_hazard_o,
  output logic [1:0]               occupancy_o,
  output logic [31:0]              stall_cycles_o
);

  typedef struct packed {
    logic [DATA_WIDTH-1:0]    aluResult;
    logic [DATA_WIDTH-1:0]    storeData;
    logic [REG_IDX_WIDTH-1:0] destReg;
    logic                     regWriteEn;
    logic                     memRead;
    logic                     memWrite;
    logic [1:0]               memSize;
  } entry_t;

  typedef struct packed {
    logic                  hit;
    logic                  hazard;
    logic [DATA_WIDTH-1:0] data;
  } fwd_t;

  localparam logic [REG_IDX_WIDTH-1:0] PC_REG = '1;

  logic   headValid_q, headValid_d;
  logic   skidValid_q, skidValid_d;
  entry_t head_q, head_d;
  entry_t skid_q, skid_d;
  entry_t inEntry;
  logic   accept;
  logic   retire;
  fwd_t   fwd1;
  fwd_t   fwd2;

  assign inEntry = '{aluResult:  alu_result_i,
                     storeData:  store_data_i,
                     destReg:    dest_reg_i,
                     regWriteEn: reg_write_en_i,
                     memRead:    mem_read_i,
                     memWrite:   mem_write_i,
                     memSize:    mem_size_i};

  assign ready_o = ~skidValid_q;
  assign valid_o = headValid_q;
  assign accept  = valid_i & ready_o;
  assign retire  = headValid_q & ready_i;

  // The skid entry is only ever filled when the head is held, so age order is head then skid.
  always_comb begin
    headValid_d = headValid_q;
    skidValid_d = skidValid_q;
    head_d      = head_q;
    skid_d      = skid_q;
    if (flush_i) begin
      headValid_d = 1'b0;
      skidValid_d = 1'b0;
    end else if (!headValid_q) begin
      if (accept) begin
        head_d      = inEntry;
        headValid_d = 1'b1;
      end
    end else if (!skidValid_q) begin
      if (retire && accept) begin
        head_d = inEntry;
      end else if (retire) begin
        headValid_d = 1'b0;
      end else if (accept) begin
        skid_d      = inEntry;
        skidValid_d = 1'b1;
      end
    end else if (retire) begin
      head_d      = skid_q;
      skidValid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      headValid_q <= 1'b0;
      skidValid_q <= 1'b0;
      head_q      <= '0;
      skid_q      <= '0;
    end else begin
      headValid_q <= headValid_d;
      skidValid_q <= skidValid_d;
      head_q      <= head_d;
      skid_q      <= skid_d;
    end
  end

  assign alu_result_o   = head_q.aluResult;
  assign store_data_o   = head_q.storeData;
  assign dest_reg_o     = head_q.destReg;
  assign reg_write_en_o = head_q.regWriteEn;
  assign mem_read_o     = head_q.memRead;
  assign mem_write_o    = head_q.memWrite;
  assign mem_size_o     = head_q.memSize;
  assign occupancy_o    = {1'b0, headValid_q} + {1'b0, skidValid_q};

  // Younger skid entry wins over head; a winning load blocks forwarding and raises the hazard.
  function automatic fwd_t lookup(input logic [REG_IDX_WIDTH-1:0] query,
                                  input logic hv, input entry_t h,
                                  input logic sv, input entry_t s);
    fwd_t   r;
    entry_t win;
    logic   headMatch;
    logic   skidMatch;
    headMatch = hv && h.regWriteEn && (h.destReg == query) && (query != PC_REG);
    skidMatch = sv && s.regWriteEn && (s.destReg == query) && (query != PC_REG);
    win       = skidMatch ? s : h;
    r.hit     = (headMatch || skidMatch) && !win.memRead;
    r.hazard  = (headMatch || skidMatch) && win.memRead;
    r.data    = win.aluResult;
    return r;
  endfunction

  assign fwd1 = lookup(fwd_query_1_i, headValid_q, head_q, skidValid_q, skid_q);
  assign fwd2 = lookup(fwd_query_2_i, headValid_q, head_q, skidValid_q, skid_q);

  assign fwd_hit_1_o       = fwd1.hit;
  assign fwd_hit_2_o       = fwd2.hit;
  assign fwd_data_1_o      = fwd1.data;
  assign fwd_data_2_o      = fwd2.data;
  assign load_use_hazard_o = fwd1.hazard | fwd2.hazard;

`ifdef EX_MEM_PERF_CNT_EN
  logic [31:0] stallCnt_q;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      stallCnt_q <= '0;
    end else if (headValid_q && !ready_i && (stallCnt_q != 32'hFFFF_FFFF)) begin
      stallCnt_q <= stallCnt_q + 32'd1;
    end
  end

  assign stall_cycles_o = stallCnt_q;
`else
  assign stall_cycles_o = '0;
`endif

endmodule

// File: doc/ex_mem_skid_stage.md
Name: ex_mem_skid_stage

Overview:
Execute-to-memory stage register placed directly downstream of the ALU wrapper. Captures ALU result, store data and writeback control into a 2-entry skid buffer, so memory-stage backpressure (ready_i low) never forms a combinational path back into execute. Also provides EX→EX operand forwarding and load-use hazard detection from its held entries.

Parameters:
DATA_WIDTH, 32, width of alu_result and store_data (matches WORD)
REG_IDX_WIDTH, 4, register index width (r0–r15)

Ports:
clk_i  input  1  clock, rising edge
reset_n_i  input  1  asynchronous active-low reset
flush_i  input  1  synchronous flush; kills all held and incoming entries
valid_i  input  1  execute presents an instruction
ready_o  output  1  stage can accept; registered, equals !skid_valid
alu_result_i  input  DATA_WIDTH  ALU result (address for loads/stores)
store_data_i  input  DATA_WIDTH  store data
dest_reg_i  input  REG_IDX_WIDTH  writeback register
reg_write_en_i  input  1  instruction writes dest_reg
mem_read_i  input  1  load
mem_write_i  input  1  store
mem_size_i  input  2  0=byte, 1=half, 2=word, 3=reserved
valid_o  output  1  head entry valid
ready_i  input  1  memory stage accepts head
alu_result_o, store_data_o, dest_reg_o, reg_write_en_o, mem_read_o, mem_write_o, mem_size_o  output  (as inputs)  head entry fields
fwd_query_1_i, fwd_query_2_i  input  REG_IDX_WIDTH  execute source registers
fwd_hit_1_o, fwd_hit_2_o  output  1  forwardable match
fwd_data_1_o, fwd_data_2_o  output  DATA_WIDTH  forwarded value
load_use_hazard_o  output  1  a query matches a pending load
occupancy_o  output  2  entries held (0,1,2)
stall_cycles_o  output  32  see Optional Feature

Behaviour:
- Storage: head entry (drives outputs) and skid entry, each with a valid bit. Age order: head older than skid.
- Async reset (reset_n_i=0): both valids 0, all head fields 0, ready_o=1, occupancy_o=0, counter 0.
- Accept = valid_i && ready_o. Retire = valid_o && ready_i. Latency: accepted data is on outputs the next cycle when the head was empty or retiring.
- Per-cycle update (no flush):
  - empty: accept → head.
  - head only: retire && accept → head←in. Retire only → empty. Accept only → skid←in, ready_o falls next cycle.
  - head+skid (ready_o=0, no accept possible): retire → head←skid, skid empty; else hold.
- Head fields never change while valid_o && !ready_i.
- flush_i=1: next cycle both valids 0 and ready_o=1. Same-cycle input dropped. Same-cycle retire still completes (memory sampled it). Flush overrides all.
- Invalid entries: data fields hold their last values; downstream must qualify with valid_o.
- Forwarding (combinational from held state only, not from inputs): match = entry valid && reg_write_en && dest_reg == query. Youngest matching entry wins (skid over head).
  - Winning entry non-load: hit=1, data=alu_result.
  - Winning entry load: hit=0 and load_use_hazard_o=1.
- Query r15 never hits (PC is sourced separately).
- mem_size=3 is passed through unchanged; not checked.

Optional Feature:
EX_MEM_PERF_CNT_EN: when defined, stall_cycles_o is a 32-bit counter incremented every cycle valid_o && !ready_i. It saturates at 0xFFFFFFFF, clears on reset, and is unaffected by flush. When undefined, stall_cycles_o is tied to 0 and no counter flops exist.

Test Plan:
- Reset mid-traffic with both entries full → valid_o=0, ready_o=1, occupancy_o=0, alu_result_o=0 immediately (async).
- Stream 4 instrs with ready_i=1 → valid_o for 4 consecutive cycles, outputs 1 cycle after each input, order preserved, ready_o stays 1.
- ready_i=0, send A=0x10 then B=0x20 → occupancy 2, ready_o=0, head holds 0x10. Raise ready_i → 0x10 then 0x20 retire, ready_o=1.
- Head r3=0x55 (ALU), skid r3=0xAA (ALU), query_1=r3 → hit_1=1, data_1=0xAA. Change skid to a load of r3 → hit_1=0, load_use_hazard_o=1.
- Two entries held, flush_i with valid_i=1 → next cycle occupancy 0, input dropped, valid_o=0.
- With EX_MEM_PERF_CNT_EN: hold ready_i=0 for 7 cycles with valid head → stall_cycles_o=7. Without the macro → stall_cycles_o=0.
